// File: rtl/write_buffer.sv
// Writeback buffer: DEPTH-entry FIFO between execute/memory and the register/CSR files,
// with x0 suppression and youngest-match forwarding. Optional flush port under WB_FLUSH_EN.
module write_buffer #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CSR_AW = 12,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef WB_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_AW-1:0]        in_rd,
  input  logic [XLEN-1:0]          in_reg_data,
  input  logic                     in_is_csr,
  input  logic [CSR_AW-1:0]        in_csr_addr,
  input  logic [XLEN-1:0]          in_csr_data,
  input  logic                     drain_en,
  output logic                     reg_w_enabled,
  output logic [REG_AW-1:0]        reg_w_addr,
  output logic [XLEN-1:0]          reg_w_data,
  output logic                     csr_w_enabled,
  output logic [CSR_AW-1:0]        csr_w_addr,
  output logic [XLEN-1:0]          csr_w_data,
  input  logic [REG_AW-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [XLEN-1:0]          fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  logic [REG_AW-1:0] r_rd       [DEPTH];
  logic [XLEN-1:0]   r_reg_data [DEPTH];
  logic              r_is_csr   [DEPTH];
  logic [CSR_AW-1:0] r_csr_addr [DEPTH];
  logic [XLEN-1:0]   r_csr_data [DEPTH];

  logic          w_flush;
  logic          w_accept;
  logic          w_store;
  logic          w_fire;
  logic [PW-1:0] w_idx;

`ifdef WB_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // in_ready depends only on held state (and reset/flush), never on drain_en or in_valid
  assign in_ready = !rst && !w_flush && (r_count != CW'(DEPTH));
  assign w_accept = in_valid && in_ready;
  assign w_store  = w_accept && ((in_rd != '0) || in_is_csr);
  assign w_fire   = drain_en && (r_count != '0) && !w_flush;
  assign count    = r_count;

  assign reg_w_enabled = w_fire && (r_rd[r_head] != '0);
  assign reg_w_addr    = reg_w_enabled ? r_rd[r_head]       : '0;
  assign reg_w_data    = reg_w_enabled ? r_reg_data[r_head] : '0;
  assign csr_w_enabled = w_fire && r_is_csr[r_head];
  assign csr_w_addr    = csr_w_enabled ? r_csr_addr[r_head] : '0;
  assign csr_w_data    = csr_w_enabled ? r_csr_data[r_head] : '0;

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    w_idx    = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (fwd_addr != '0) && (r_rd[w_idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_reg_data[w_idx];
      end
    end
    if (w_flush) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_store) r_tail <= r_tail + PW'(1);
      if (w_fire)  r_head <= r_head + PW'(1);
      case ({w_store, w_fire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_rd[r_tail]       <= in_rd;
      r_reg_data[r_tail] <= in_reg_data;
      r_is_csr[r_tail]   <= in_is_csr;
      r_csr_addr[r_tail] <= in_csr_addr;
      r_csr_data[r_tail] <= in_csr_data;
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: stimulus pushes expected retire writes into a queue,
// a negedge monitor pops and compares whenever a write strobe is presented.
`timescale 1ns/1ps
module tb_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_reg_data;
  logic        in_is_csr;
  logic [11:0] in_csr_addr;
  logic [31:0] in_csr_data;
  logic        drain_en;
  logic        reg_w_enabled;
  logic [4:0]  reg_w_addr;
  logic [31:0] reg_w_data;
  logic        csr_w_enabled;
  logic [11:0] csr_w_addr;
  logic [31:0] csr_w_data;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;
`ifdef WB_FLUSH_EN
  logic        flush;
`endif

  typedef struct packed {
    logic        re;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        ce;
    logic [11:0] ca;
    logic [31:0] cd;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  write_buffer #(.XLEN(32), .REG_AW(5), .CSR_AW(12), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef WB_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rd(in_rd),
    .in_reg_data(in_reg_data),
    .in_is_csr(in_is_csr),
    .in_csr_addr(in_csr_addr),
    .in_csr_data(in_csr_data),
    .drain_en(drain_en),
    .reg_w_enabled(reg_w_enabled),
    .reg_w_addr(reg_w_addr),
    .reg_w_data(reg_w_data),
    .csr_w_enabled(csr_w_enabled),
    .csr_w_addr(csr_w_addr),
    .csr_w_data(csr_w_data),
    .fwd_addr(fwd_addr),
    .fwd_hit(fwd_hit),
    .fwd_data(fwd_data),
    .count(count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (reg_w_enabled || csr_w_enabled)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual reg=%0b/%0h/%0h csr=%0b/%0h/%0h required none",
                 reg_w_enabled, reg_w_addr, reg_w_data, csr_w_enabled, csr_w_addr, csr_w_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("reg_w_enabled", 64'(reg_w_enabled), 64'(e.re));
        chk("reg_w_addr",    64'(reg_w_addr),    64'(e.ra));
        chk("reg_w_data",    64'(reg_w_data),    64'(e.rd));
        chk("csr_w_enabled", 64'(csr_w_enabled), 64'(e.ce));
        chk("csr_w_addr",    64'(csr_w_addr),    64'(e.ca));
        chk("csr_w_data",    64'(csr_w_data),    64'(e.cd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [4:0] rd, input logic [31:0] d, input logic csr,
                     input logic [11:0] ca, input logic [31:0] cd, input logic expect_store);
    in_valid    = 1'b1;
    in_rd       = rd;
    in_reg_data = d;
    in_is_csr   = csr;
    in_csr_addr = ca;
    in_csr_data = cd;
    if (expect_store)
      exp_q.push_back('{re: (rd != 0), ra: rd, rd: (rd != 0) ? d : 32'h0,
                        ce: csr, ca: csr ? ca : 12'h0, cd: csr ? cd : 32'h0});
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_reg_data = '0; in_is_csr = 1'b0;
    in_csr_addr = '0; in_csr_data = '0; drain_en = 1'b0; fwd_addr = '0;
`ifdef WB_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_count",    64'(count),    64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // fill to full, backpressure, then drain in order
    for (int i = 1; i <= 4; i++)
      enq(5'(i), 32'(i * 32'h11), 1'b0, 12'h0, 32'h0, 1'b1);
    chk("full_count",    64'(count),    64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    fwd_addr = 5'd3;
    #1;
    chk("full_fwd_hit",  64'(fwd_hit),  64'd1);
    chk("full_fwd_data", 64'(fwd_data), 64'h33);
    tick();
    enq(5'd5, 32'h55, 1'b0, 12'h0, 32'h0, 1'b0);
    chk("fifth_rejected_count", 64'(count), 64'd4);
    drain_en = 1'b1;
    repeat (4) tick();
    drain_en = 1'b0;
    chk("drained_count", 64'(count), 64'd0);
    drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    chk("empty_drain_count", 64'(count), 64'd0);

    // x0 suppression and CSR-only entries
    enq(5'd0, 32'hDEAD, 1'b0, 12'h0, 32'h0, 1'b0);
    chk("x0_count", 64'(count), 64'd0);
    enq(5'd0, 32'h0, 1'b1, 12'h300, 32'h8, 1'b1);
    chk("csr_only_count", 64'(count), 64'd1);
    drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    chk("csr_drained_count", 64'(count), 64'd0);

    // simultaneous enqueue and retire across pointer wrap
    enq(5'd10, 32'h100, 1'b0, 12'h0, 32'h0, 1'b1);
    enq(5'd11, 32'h101, 1'b0, 12'h0, 32'h0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      drain_en = 1'b1;
      enq(5'(12 + k), 32'(32'h200 + k), 1'b0, 12'h0, 32'h0, 1'b1);
      chk("simul_count", 64'(count), 64'd2);
    end
    repeat (2) tick();
    drain_en = 1'b0;
    chk("simul_drained_count", 64'(count), 64'd0);

    // forwarding: youngest match wins
    enq(5'd7, 32'hA, 1'b0, 12'h0, 32'h0, 1'b1);
    enq(5'd3, 32'hB, 1'b0, 12'h0, 32'h0, 1'b1);
    enq(5'd7, 32'hC, 1'b0, 12'h0, 32'h0, 1'b1);
    fwd_addr = 5'd7; #1;
    chk("fwd7_hit",  64'(fwd_hit),  64'd1);
    chk("fwd7_data", 64'(fwd_data), 64'hC);
    tick();
    fwd_addr = 5'd3; #1;
    chk("fwd3_hit",  64'(fwd_hit),  64'd1);
    chk("fwd3_data", 64'(fwd_data), 64'hB);
    tick();
    fwd_addr = 5'd0; #1;
    chk("fwd0_hit",  64'(fwd_hit),  64'd0);
    chk("fwd0_data", 64'(fwd_data), 64'h0);
    tick();
    fwd_addr = 5'd9; #1;
    chk("fwd9_hit",  64'(fwd_hit),  64'd0);
    chk("fwd9_data", 64'(fwd_data), 64'h0);
    tick();

    // asynchronous reset mid-operation with count=3
    chk("pre_rst_count", 64'(count), 64'd3);
    exp_q.delete();
    drain_en = 1'b1;
    fwd_addr = 5'd7;
    rst = 1'b1;
    #1;
    chk("mid_rst_count",    64'(count),         64'd0);
    chk("mid_rst_reg_we",   64'(reg_w_enabled), 64'd0);
    chk("mid_rst_csr_we",   64'(csr_w_enabled), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready),      64'd0);
    chk("mid_rst_fwd_hit",  64'(fwd_hit),       64'd0);
    tick();
    rst = 1'b0;
    drain_en = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    tick();
    enq(5'd5, 32'h55, 1'b0, 12'h0, 32'h0, 1'b1);
    drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    chk("after_rst_count", 64'(count), 64'd0);

`ifdef WB_FLUSH_EN
    enq(5'd1, 32'h1, 1'b0, 12'h0, 32'h0, 1'b1);
    enq(5'd2, 32'h2, 1'b0, 12'h0, 32'h0, 1'b1);
    enq(5'd3, 32'h3, 1'b0, 12'h0, 32'h0, 1'b1);
    exp_q.delete();
    flush = 1'b1; drain_en = 1'b1; in_valid = 1'b1; in_rd = 5'd9; in_reg_data = 32'h99;
    #1;
    chk("flush_in_ready", 64'(in_ready),      64'd0);
    chk("flush_reg_we",   64'(reg_w_enabled), 64'd0);
    chk("flush_csr_we",   64'(csr_w_enabled), 64'd0);
    tick();
    flush = 1'b0; drain_en = 1'b0; in_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
`endif

    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
